// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing generator on the pixel clock.
// Produces active-low HSYNC/VSYNC, blank flag, pixel coordinates, a linear
// active-pixel address and frame status, all from one output register stage.
// Build option: define VGA_TIMING_ADDR_EN to compile in the incremental oADDR
// generator; when undefined, oADDR is tied to zero.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    output logic        oBLANK_n,
    output logic        oHS,
    output logic        oVS,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic [18:0] oADDR,
    output logic        oFRAME_START,
    output logic [15:0] oFRAME_CNT
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
    localparam logic [9:0] HActive    = 10'(H_ACTIVE);
    localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
    localparam logic [9:0] VActive    = 10'(V_ACTIVE);
    localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        blank_n_q, blank_n_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    // Set until the first frame start after reset, which must not be counted.
    logic        first_q, first_d;

    // Advance the raster position; h wraps every line, v wraps every frame.
    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == HLast) begin
            h_d = '0;
            v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
        end
    end

    // Decode the next position so every registered output matches (h_d, v_d).
    always_comb begin
        blank_n_d     = (h_d < HActive) && (v_d < VActive);
        hs_d          = !((h_d >= HSyncStart) && (h_d < HSyncEnd));
        vs_d          = !((v_d >= VSyncStart) && (v_d < VSyncEnd));
        frame_start_d = (h_d == '0) && (v_d == '0);
        first_d       = first_q;
        frame_cnt_d   = frame_cnt_q;
        if (frame_start_d) begin
            first_d = 1'b0;
            if (!first_q) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    // Position counters and timing outputs; reset parks h/v on the last pixel.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            h_q           <= HLast;
            v_q           <= VLast;
            blank_n_q     <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            first_q       <= 1'b1;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            blank_n_q     <= blank_n_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            first_q       <= first_d;
        end
    end

`ifdef VGA_TIMING_ADDR_EN
    logic [18:0] addr_q, addr_d;

    // Linear address: restart at (0,0), step on active pixels, hold in blanking.
    always_comb begin
        addr_d = addr_q;
        if (frame_start_d) begin
            addr_d = '0;
        end else if (blank_n_d) begin
            addr_d = addr_q + 19'd1;
        end
    end

    // Address register, reset to zero alongside the timing outputs.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign oADDR = addr_q;
`else
    assign oADDR = '0;
`endif

    // Coordinates read zero during reset even though h/v hold their last values.
    logic in_reset_n_q;

    // Tracks whether the first post-reset edge has happened.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            in_reset_n_q <= 1'b0;
        end else begin
            in_reset_n_q <= 1'b1;
        end
    end

    assign oBLANK_n     = blank_n_q;
    assign oHS          = hs_q;
    assign oVS          = vs_q;
    assign oX           = in_reset_n_q ? h_q : 10'd0;
    assign oY           = in_reset_n_q ? v_q : 10'd0;
    assign oFRAME_START = frame_start_q;
    assign oFRAME_CNT   = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz VGA path. It runs on the pixel clock and produces active-low HSYNC/VSYNC, the active-video blank flag, the current pixel coordinates, a linear framebuffer address and frame-level status. It sits directly upstream of the VGA controller, which consumes oBLANK_n/oHS/oVS to advance its framebuffer address and delay sync. The CPU-side VGA memory write logic uses oFRAME_START to time its writes.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

- iVGA_CLK  input  1  pixel clock, 25.175 MHz nominal, rising-edge
- iRST_n  input  1  asynchronous, active-low reset
- oBLANK_n  output  1  1 = active video pixel
- oHS  output  1  horizontal sync, active low
- oVS  output  1  vertical sync, active low
- oX  output  10  horizontal counter value, 0..H_TOTAL-1
- oY  output  10  vertical counter value, 0..V_TOTAL-1
- oADDR  output  19  linear active-pixel index, 0..H_ACTIVE*V_ACTIVE-1
- oFRAME_START  output  1  one-cycle pulse at pixel (0,0)
- oFRAME_CNT  output  16  completed-frame count, wraps modulo 2^16

## Operation
- H_TOTAL = sum of the H parameters (800). V_TOTAL = sum of the V parameters (525). One frame is 420000 clocks.
- Horizontal counter h runs 0..H_TOTAL-1 and wraps to 0. The vertical counter v increments when h wraps, and wraps to 0 after V_TOTAL-1.
- Region order per line: active h=0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Region order per frame: active v=0..479, front porch 480..489, sync 490..491, back porch 492..524.
- oBLANK_n = (h < H_ACTIVE) && (v < V_ACTIVE).
- oHS = 0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. This holds on every line, including vertical blanking lines.
- oVS = 0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. The transition coincides with h = 0.
- oX = h, oY = v.
- oADDR is incremental; no multiplier is used.
  - At (0,0) it is 0.
  - On each subsequent active pixel it is the previous active value +1.
  - It holds its value through blanking.
  - Its value at (639,479) is 307199.
- oFRAME_START = 1 only on the cycle where (h,v) = (0,0).
- oFRAME_CNT increments by 1 on the same cycle as each oFRAME_START, except the first one after reset. It wraps 0xFFFF -> 0x0000.
- All outputs are registered. Every output describes the same (h,v) position in the same cycle, so there is no skew between outputs.

## Timing
- Reset (async assert, any time including mid-frame):
  - Internal counters load h = H_TOTAL-1, v = V_TOTAL-1.
  - Output values: oBLANK_n=0, oHS=1, oVS=1, oX=0, oY=0, oADDR=0, oFRAME_START=0, oFRAME_CNT=0.
- First rising edge after reset deassertion: (h,v) = (0,0), oBLANK_n=1, oFRAME_START=1, oADDR=0, oFRAME_CNT stays 0.
- Latency: none beyond the single output register. Counter state and outputs change on the same edge.
- Wrap boundaries:
  - (799,v) -> (0,v+1).
  - (799,524) -> (0,0), with oFRAME_START=1 and oFRAME_CNT+1 on that edge.
- The block has no stall or enable input. It free-runs whenever reset is deasserted.

## Configuration
- VGA_TIMING_ADDR_EN defined: the oADDR incremental generator is compiled in, as specified above.
- VGA_TIMING_ADDR_EN undefined: the oADDR logic is removed and oADDR is tied to 19'd0. The downstream controller then generates its own address from oBLANK_n/oHS/oVS. All other outputs are unaffected.

## Test plan
- Reset release:
  - Stimulus: hold iRST_n=0 for 5 clocks, then release.
  - Check: outputs equal reset values while held.
  - Check: the first edge after release gives oX=0, oY=0, oBLANK_n=1, oFRAME_START=1, oADDR=0, oFRAME_CNT=0.
- Line timing: over one line, oBLANK_n=1 for exactly 640 clocks, oHS=0 for exactly 96 clocks starting at oX=656, and the line period is 800 clocks.
- Frame timing:
  - oVS=0 for exactly 1600 clocks, starting at (0,490).
  - oFRAME_START pulses exactly every 420000 clocks.
  - oFRAME_CNT=3 after the fourth pulse.
- Address sequence (macro defined):
  - Check: oADDR=639 at (639,0), 640 at (0,1), and 307199 at (639,479).
  - Check: oADDR holds 307199 through vertical blanking and returns to 0 at (0,0).
- Mid-frame reset: assert iRST_n=0 at (300,200) for 3 clocks. Outputs return to reset values asynchronously, and the next post-release edge gives (0,0) with oFRAME_START=1 and oFRAME_CNT=0.
- Macro undefined: run one full frame; oADDR is 0 on every cycle, and HS/VS/blank timing is identical to the macro-defined run.
